// File: rtl/cipher_pkg.sv
// Shared cipher definitions for the encryption/decryption pair.
// Default geometry, FSM state encoding and width-generic helper functions.
// The helpers work on a MAX_N-bit word and take the live width as an argument.
// This lets any instance width up to MAX_N reuse them.
package cipher_pkg;

    localparam int N      = 8;
    localparam int ROUNDS = 4;
    localparam int ROT    = 3;

    localparam int MAX_N  = 64;

    typedef logic [MAX_N-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Mask selecting the low w bits of a word.
    function automatic word_t width_mask(input int w);
        if (w >= MAX_N) return '1;
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    // Rotate the low w bits of x left by s (taken modulo w).
    function automatic word_t rotl(input word_t x, input int s, input int w);
        word_t xm;
        int    sh;
        xm = x & width_mask(w);
        sh = s % w;
        if (sh == 0) return xm;
        return ((xm << sh) | (xm >> (w - sh))) & width_mask(w);
    endfunction

    // Rotate the low w bits of x right by s (taken modulo w).
    function automatic word_t rotr(input word_t x, input int s, input int w);
        return rotl(x, w - (s % w), w);
    endfunction

    // Round key r is the cipher key rotated left by r modulo the width.
    function automatic word_t round_key(input word_t key, input int r, input int w);
        return rotl(key, r % w, w);
    endfunction

    // MAC carried alongside the ciphertext: rotl(plain, 1) ^ key.
    function automatic word_t mac_calc(input word_t plain, input word_t key, input int w);
        return (rotl(plain, 1, w) ^ key) & width_mask(w);
    endfunction

endpackage

// File: rtl/decryption_if.sv
// Bus bundle between the link receiver and the decryptor.
// Optional MAC signals are present only when DECRYPTION_MAC_CHECK_EN is defined.
//
// Handshake: both channels are valid/ready. A beat transfers on a rising clock
// edge where valid and ready are both 1. A producer holds valid and its payload
// steady until that edge. ready may be asserted independently of valid.
interface decryption_if #(parameter int N = 8);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] e_data;
    logic [N-1:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] data;
`ifdef DECRYPTION_MAC_CHECK_EN
    logic [N-1:0] e_mac;
    logic         mac_ok;

    modport master (output in_valid, e_data, key, e_mac, out_ready,
                    input  in_ready, out_valid, data, mac_ok);
    modport slave  (input  in_valid, e_data, key, e_mac, out_ready,
                    output in_ready, out_valid, data, mac_ok);
`else
    modport master (output in_valid, e_data, key, out_ready,
                    input  in_ready, out_valid, data);
    modport slave  (input  in_valid, e_data, key, out_ready,
                    output in_ready, out_valid, data);
`endif

endinterface

// File: rtl/decryption_round.sv
// One inverse cipher round, purely combinational:
// x_next = rotr((x - k_r) mod 2^N, ROT) ^ k_r, where k_r = rotl(key, r mod N).
module decryption_round #(
    parameter int N   = 8,
    parameter int ROT = 3,
    parameter int RW  = 2
) (
    input  logic [N-1:0]  x,
    input  logic [N-1:0]  key,
    input  logic [RW-1:0] r,
    output logic [N-1:0]  x_next
);
    import cipher_pkg::*;

    word_t k_r;
    word_t diff;

    // Undo the add, then the rotate, then the key XOR of the matching encrypt round.
    always_comb begin
        k_r    = round_key(word_t'(x) & '0 | word_t'(key), int'(r), N);
        diff   = (word_t'(x) - k_r) & width_mask(N);
        x_next = N'(rotr(diff, ROT, N) ^ k_r);
    end

endmodule

// File: rtl/decryption.sv
// Iterative decryptor: accepts ciphertext and key, then runs ROUNDS inverse
// rounds (last round first), one per clock, and presents the plaintext.
// Optional MAC check is compiled in with DECRYPTION_MAC_CHECK_EN.
module decryption #(
    parameter int N      = cipher_pkg::N,
    parameter int ROUNDS = cipher_pkg::ROUNDS,
    parameter int ROT    = cipher_pkg::ROT
) (
    input  logic                clock,
    input  logic                reset_n,
    decryption_if.slave         bus,
    output cipher_pkg::state_t  dbg_state
);
    import cipher_pkg::*;

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  x_q;
    logic [N-1:0]  key_q;
    logic [N-1:0]  x_next;
    logic          accept;

    decryption_round #(.N(N), .ROT(ROT), .RW(CW)) u_round (
        .x      (x_q),
        .key    (key_q),
        .r      (cnt_q),
        .x_next (x_next)
    );

    // Ready only in IDLE and never while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && reset_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.data      = x_q;
    assign dbg_state     = state_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Next-state logic: IDLE -> ROUND on accept, ROUND -> DONE after round 0, DONE -> IDLE on consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ROUND;
            ROUND:   if (cnt_q == '0) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Working register, latched key and round counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            key_q <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE && accept) begin
            x_q   <= bus.e_data;
            key_q <= bus.key;
            cnt_q <= CW'(ROUNDS - 1);
        end else if (state_q == ROUND) begin
            x_q <= x_next;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

`ifdef DECRYPTION_MAC_CHECK_EN
    logic [N-1:0] e_mac_q;
    logic         mac_ok_q;

    assign bus.mac_ok = mac_ok_q;

    // MAC is judged on the final round output and cleared when the result is consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e_mac_q  <= '0;
            mac_ok_q <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            e_mac_q  <= bus.e_mac;
            mac_ok_q <= 1'b0;
        end else if (state_q == ROUND && cnt_q == '0) begin
            mac_ok_q <= (N'(mac_calc(word_t'(x_next), word_t'(key_q), N)) == e_mac_q);
        end else if (state_q == DONE && bus.out_ready) begin
            mac_ok_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_decryption.sv
// Directed and randomised checks for the decryptor.
// The table vectors carry hand-computed plaintexts. The random vectors are
// encrypted by a bench-local forward cipher. MAC checks follow DECRYPTION_MAC_CHECK_EN.
module tb_decryption;
    import cipher_pkg::*;

    localparam int TN   = 8;
    localparam int TR   = 4;
    localparam int TROT = 3;

    // ---------------- clock / reset ----------------
    logic   clock   = 1'b0;
    logic   reset_n = 1'b0;
    state_t dbg_state;

    always #5 clock = ~clock;

    decryption_if #(.N(TN)) bif ();

    decryption #(.N(TN), .ROUNDS(TR), .ROT(TROT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bif),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [TN-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- golden forward cipher ----------------
    function automatic logic [TN-1:0] b_rotl(input logic [TN-1:0] x, input int s);
        int k;
        k = s % TN;
        if (k == 0) return x;
        return (x << k) | (x >> (TN - k));
    endfunction

    function automatic logic [TN-1:0] b_encrypt(input logic [TN-1:0] p, input logic [TN-1:0] k);
        logic [TN-1:0] x;
        logic [TN-1:0] kr;
        x = p;
        for (int r = 0; r < TR; r++) begin
            kr = b_rotl(k, r);
            x  = b_rotl(x ^ kr, TROT) + kr;
        end
        return x;
    endfunction

    // ---------------- driver ----------------
    // One full transaction: accept, scramble inputs during rounds, check latency,
    // result, optional MAC, hold for 'hold' cycles under backpressure, then consume.
    task automatic run_txn(input logic [TN-1:0] e, input logic [TN-1:0] k,
                           input logic [TN-1:0] m, input logic [TN-1:0] exp_d,
                           input logic exp_ok, input int hold, input string tag);
        int            lat;
        logic [TN-1:0] exp;
        @(negedge clock);
        check($sformatf("%s_rdy_idle", tag), 32'(bif.in_ready), 32'd1);
        bif.in_valid  = 1'b1;
        bif.e_data    = e;
        bif.key       = k;
`ifdef DECRYPTION_MAC_CHECK_EN
        bif.e_mac     = m;
`endif
        bif.out_ready = (hold == 0);
        exp_q.push_back(exp_d);
        @(posedge clock);
        #1;
        bif.in_valid = 1'b0;
        check($sformatf("%s_rdy_busy", tag), 32'(bif.in_ready), 32'd0);
        bif.e_data = TN'($urandom);
        bif.key    = TN'($urandom);
`ifdef DECRYPTION_MAC_CHECK_EN
        bif.e_mac  = TN'($urandom);
`endif
        lat = 0;
        while (!bif.out_valid && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check($sformatf("%s_latency", tag), 32'(lat), 32'(TR));
        exp = exp_q.pop_front();
        check($sformatf("%s_data", tag), 32'(bif.data), 32'(exp));
`ifdef DECRYPTION_MAC_CHECK_EN
        check($sformatf("%s_mac_ok", tag), 32'(bif.mac_ok), 32'(exp_ok));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s_hold_data", tag), 32'(bif.data), 32'(exp));
            check($sformatf("%s_hold_valid", tag), 32'(bif.out_valid), 32'd1);
            check($sformatf("%s_hold_rdy", tag), 32'(bif.in_ready), 32'd0);
        end
        @(negedge clock);
        bif.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check($sformatf("%s_valid_fall", tag), 32'(bif.out_valid), 32'd0);
        check($sformatf("%s_rdy_rise", tag), 32'(bif.in_ready), 32'd1);
`ifdef DECRYPTION_MAC_CHECK_EN
        check($sformatf("%s_mac_clr", tag), 32'(bif.mac_ok), 32'd0);
`endif
        bif.out_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [TN-1:0] e_data;
        logic [TN-1:0] key;
        logic [TN-1:0] e_mac;
        logic [TN-1:0] exp_data;
        logic          exp_ok;
        int            hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int            seen;
        logic [TN-1:0] p;
        logic [TN-1:0] k;

        vecs[0] = '{8'h21, 8'h00, 8'h24, 8'h12, 1'b1, 0};
        vecs[1] = '{8'hFF, 8'h01, 8'h01, 8'h00, 1'b1, 0};
        vecs[2] = '{8'hFF, 8'h01, 8'h02, 8'h00, 1'b0, 0};
        vecs[3] = '{8'h80, 8'h00, 8'h10, 8'h08, 1'b1, 2};
        vecs[4] = '{8'h00, 8'hFF, 8'h19, 8'h73, 1'b1, 10};
        vecs[5] = '{8'h01, 8'h00, 8'h21, 8'h10, 1'b0, 0};

        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        bif.e_data    = '0;
        bif.key       = '0;
`ifdef DECRYPTION_MAC_CHECK_EN
        bif.e_mac     = '0;
`endif

        // Reset values while held and after release.
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready_low", 32'(bif.in_ready), 32'd0);
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_data", 32'(bif.data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef DECRYPTION_MAC_CHECK_EN
        check("rst_mac_ok", 32'(bif.mac_ok), 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_in_ready_high", 32'(bif.in_ready), 32'd1);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            run_txn(vecs[i].e_data, vecs[i].key, vecs[i].e_mac, vecs[i].exp_data,
                    vecs[i].exp_ok, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle while a result is presented.
        @(negedge clock);
        bif.in_valid = 1'b1;
        bif.e_data   = 8'h21;
        bif.key      = 8'h00;
        @(posedge clock);
        #1;
        bif.in_valid = 1'b0;
        repeat (TR) @(posedge clock);
        #3;
        check("arst_pre_valid", 32'(bif.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bif.out_valid), 32'd0);
        check("arst_data", 32'(bif.data), 32'd0);
        check("arst_in_ready", 32'(bif.in_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("arst_in_ready_rel", 32'(bif.in_ready), 32'd1);

        // Reset after two rounds: no result may ever appear.
        @(negedge clock);
        bif.in_valid = 1'b1;
        bif.e_data   = 8'hFF;
        bif.key      = 8'h01;
        @(posedge clock);
        #1;
        bif.in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        check("rrst_in_round", 32'(dbg_state), 32'(ROUND));
        reset_n = 1'b0;
        #1;
        check("rrst_state", 32'(dbg_state), 32'(IDLE));
        check("rrst_data", 32'(bif.data), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < TR + 4; i++) begin
            @(posedge clock);
            #1;
            if (bif.out_valid) seen++;
        end
        check("rrst_no_valid", 32'(seen), 32'd0);
        run_txn(vecs[0].e_data, vecs[0].key, vecs[0].e_mac, vecs[0].exp_data,
                vecs[0].exp_ok, 0, "rrst_next");

        // Round trip against the forward cipher.
        for (int i = 0; i < 1000; i++) begin
            p = TN'($urandom);
            k = TN'($urandom);
            run_txn(b_encrypt(p, k), k, b_rotl(p, 1) ^ k, p, 1'b1,
                    $urandom_range(0, 2), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
